dual_pass_threshold_reader: RTL and testbench
=============================================

Name: dual_pass_threshold_reader

Overview:
- Consumer end of the dual-read pixel FIFO. It drives the FIFO read side and sees each frame twice.
- Pass 1: accumulates pixel statistics and computes a global threshold.
- Pass 2: re-reads the same pixels and emits a 1-bit binarised stream.
- Sits between the pixel FIFO and the binary-image output stage of the thresholding pipeline.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- FRAME_PIXELS, 4, pixels per frame. Must be a power of 2 and at least 2. Equals the FIFO depth.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  single-cycle pulse; begins a frame. Ignored unless in IDLE.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_WIDTH  FIFO registered read data; valid 1 cycle after an accepted read.
- fifo_read_en  out  1  FIFO read request.
- threshold  out  DATA_WIDTH  computed threshold; held until the next CALC.
- pix_out  out  1  1 when pixel >= threshold, else 0.
- pix_out_valid  out  1  pix_out qualifier. No backpressure.
- busy  out  1  high in every state except IDLE.
- done  out  1  1-cycle pulse after the last pass-2 output.

Behaviour:
- Reset values: fifo_read_en=0, threshold=0, pix_out=0, pix_out_valid=0, busy=0, done=0. State=IDLE; all counters and accumulators 0.
- FSM states: IDLE, PASS1, CALC, PASS2, DONE.
  - IDLE -> PASS1 on start.
  - PASS1 -> CALC when rx_cnt reaches FRAME_PIXELS.
  - CALC -> PASS2 after exactly 1 cycle.
  - PASS2 -> DONE when rx_cnt reaches FRAME_PIXELS.
  - DONE -> IDLE after 1 cycle; done=1 during DONE.
- Read issue: fifo_read_en is combinational = (state is PASS1 or PASS2) && !fifo_empty && issue_cnt < FRAME_PIXELS.
  - An accepted read (fifo_read_en=1) increments issue_cnt.
  - Throughput: 1 read per cycle while the FIFO is non-empty.
- Read response: rd_pending register <= accepted read. When rd_pending=1, fifo_data is consumed that cycle and rx_cnt increments.
  - A read issue and a data consume in the same cycle is normal pipelined operation.
- Counters issue_cnt and rx_cnt: width $clog2(FRAME_PIXELS)+1. Both clear on entry to PASS1 and on entry to PASS2.
- PASS1: sum += fifo_data on each consume.
  - sum width = DATA_WIDTH + $clog2(FRAME_PIXELS); the sum cannot overflow.
  - sum clears on entry to PASS1.
- CALC: threshold <= sum >> $clog2(FRAME_PIXELS). This is the truncated mean; it always fits in DATA_WIDTH.
- PASS2: on each consume, registered output the next cycle: pix_out=(fifo_data >= threshold), pix_out_valid=1.
  - Consume latency from read issue to output: 2 cycles.
  - Last output coincides with the DONE cycle.
- FIFO stall (fifo_empty=1 mid-pass): fifo_read_en=0. No duplicate consume, no output gap corruption; resume when the FIFO is non-empty.
- Empty at start: remain in PASS1 issuing nothing until data arrives; no timeout.
- FIFO empty flag stays low between passes, so PASS2 starts without a refill.
- start while busy: ignored, no effect on counters.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. A partial frame is discarded.
- Back-to-back: a start in the same cycle as the IDLE return (cycle after DONE) is accepted.

Optional Feature:
- Macro: MIDRANGE_THRESH_EN.
- Defined:
  - PASS1 additionally tracks min and max; both are initialised from the first consumed pixel.
  - CALC sets threshold <= (min + max) >> 1, computed at DATA_WIDTH+1 bits then truncated.
  - The sum logic is removed.
- Undefined: mean threshold as above; no min/max registers.

Decomposition:
- Package thresh_pkg:
  - state enum typedef (IDLE, PASS1, CALC, PASS2, DONE).
  - localparam functions for CNT_WIDTH and SUM_WIDTH from FRAME_PIXELS/DATA_WIDTH.
  - elaboration check that FRAME_PIXELS is a power of 2.
- Sub-module pixel_stats_accum: clear, valid and data in; sum, or min/max under the macro, out. The top level keeps the FSM, counters and the compare.

Test Plan:
- Basic: FRAME_PIXELS=4, write 10,20,30,40, start -> threshold=25 after CALC; pix_out 0,0,1,1; done pulse once; busy low after.
- Saturation: pixels 255,255,255,255 -> sum=1020, threshold=255, outputs 1,1,1,1. With MIDRANGE_THRESH_EN: threshold=255.
- Mean vs midrange: pixels 10,10,10,250 -> mean build threshold=70; midrange build threshold=130. Outputs 0,0,0,1 in both builds.
- Stall: hold fifo_empty=1 for 3 cycles after the 2nd pass-1 read -> fifo_read_en low throughout; exactly 4 consumes per pass; exactly 4 pix_out_valid pulses.
- Control: start pulsed during PASS2 is ignored. Assert reset mid-PASS2 -> all outputs 0 next edge, state IDLE. A new frame then completes correctly.
- Back-to-back: two frames (10,20,30,40 then 200,0,0,0; thresholds 25 and 50) -> pass-2 outputs 0,0,1,1 then 1,0,0,0; two done pulses.

Source files
------------

// File: rtl/dual_pass_threshold_reader_pkg.sv
// Shared types and width helpers for the dual-pass threshold reader.
package thresh_pkg;

  typedef enum logic [2:0] {IDLE, PASS1, CALC, PASS2, DONE} state_t;

  function automatic int cnt_width(input int frame_pixels);
    return $clog2(frame_pixels) + 1;
  endfunction

  function automatic int sum_width(input int data_width, input int frame_pixels);
    return data_width + $clog2(frame_pixels);
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/dual_pass_threshold_reader_if.sv
// FIFO read-side bundle; the reader is the master (it issues reads).
interface dual_pass_threshold_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_read_en;

  modport master (input fifo_empty, input fifo_data, output fifo_read_en);
  modport slave  (output fifo_empty, output fifo_data, input fifo_read_en);
endinterface

// File: rtl/dual_pass_threshold_reader_stats.sv
// Pass-1 pixel statistics: running sum, or min/max when MIDRANGE_THRESH_EN is defined.
module pixel_stats_accum
  import thresh_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int FRAME_PIXELS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] data,
`ifdef MIDRANGE_THRESH_EN
  output logic [DATA_WIDTH-1:0] min_val,
  output logic [DATA_WIDTH-1:0] max_val
`else
  output logic [sum_width(DATA_WIDTH, FRAME_PIXELS)-1:0] sum
`endif
);

`ifdef MIDRANGE_THRESH_EN
  // seen gates the first pixel so both extremes start from real data.
  logic seen;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen    <= 1'b0;
      min_val <= '0;
      max_val <= '0;
    end else if (clear) begin
      seen    <= 1'b0;
      min_val <= '0;
      max_val <= '0;
    end else if (valid) begin
      seen <= 1'b1;
      if (!seen || data < min_val) min_val <= data;
      if (!seen || data > max_val) max_val <= data;
    end
  end
`else
  localparam int SW = sum_width(DATA_WIDTH, FRAME_PIXELS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      sum <= '0;
    else if (clear) sum <= '0;
    else if (valid) sum <= sum + SW'(data);
  end
`endif

endmodule

// File: rtl/dual_pass_threshold_reader.sv
// Reads each frame twice from the pixel FIFO: pass 1 builds a global threshold,
// pass 2 binarises. Macro MIDRANGE_THRESH_EN selects midrange instead of mean.
module dual_pass_threshold_reader
  import thresh_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int FRAME_PIXELS = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  dual_pass_threshold_reader_if.master fifo,
  output logic [DATA_WIDTH-1:0]       threshold,
  output logic                        pix_out,
  output logic                        pix_out_valid,
  output logic                        busy,
  output logic                        done
);

  localparam int CW = cnt_width(FRAME_PIXELS);

  if (!is_pow2(FRAME_PIXELS)) begin : g_bad_frame
    $error("FRAME_PIXELS must be a power of 2 and at least 2");
  end

  state_t          state, next_state;
  logic [CW-1:0]   issue_cnt, rx_cnt;
  logic            rd_pending;
  logic            in_pass, enter_pass, last_rx;

  assign in_pass    = (state == PASS1) || (state == PASS2);
  assign enter_pass = ((state == IDLE) && start) || (state == CALC);
  assign last_rx    = rd_pending && (rx_cnt == CW'(FRAME_PIXELS - 1));

  assign fifo.fifo_read_en = in_pass && !fifo.fifo_empty && (issue_cnt < CW'(FRAME_PIXELS));
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Leave a pass on the final consume so CALC/DONE line up with the last data.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start)   next_state = PASS1;
      PASS1:   if (last_rx) next_state = CALC;
      CALC:                 next_state = PASS2;
      PASS2:   if (last_rx) next_state = DONE;
      DONE:                 next_state = IDLE;
      default:              next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_cnt  <= '0;
      rx_cnt     <= '0;
      rd_pending <= 1'b0;
    end else if (enter_pass) begin
      issue_cnt  <= '0;
      rx_cnt     <= '0;
      rd_pending <= 1'b0;
    end else begin
      rd_pending <= fifo.fifo_read_en;
      if (fifo.fifo_read_en) issue_cnt <= issue_cnt + 1'b1;
      if (rd_pending)        rx_cnt    <= rx_cnt + 1'b1;
    end
  end

  logic [DATA_WIDTH-1:0] calc_thresh;

`ifdef MIDRANGE_THRESH_EN
  logic [DATA_WIDTH-1:0] min_val, max_val;
  logic [DATA_WIDTH:0]   mid_sum;

  pixel_stats_accum #(.DATA_WIDTH(DATA_WIDTH), .FRAME_PIXELS(FRAME_PIXELS)) u_stats (
    .clk     (clk),
    .reset   (reset),
    .clear   ((state == IDLE) && start),
    .valid   (rd_pending && (state == PASS1)),
    .data    (fifo.fifo_data),
    .min_val (min_val),
    .max_val (max_val)
  );

  assign mid_sum     = {1'b0, min_val} + {1'b0, max_val};
  assign calc_thresh = mid_sum[DATA_WIDTH:1];
`else
  localparam int SW = sum_width(DATA_WIDTH, FRAME_PIXELS);
  logic [SW-1:0] sum;

  pixel_stats_accum #(.DATA_WIDTH(DATA_WIDTH), .FRAME_PIXELS(FRAME_PIXELS)) u_stats (
    .clk   (clk),
    .reset (reset),
    .clear ((state == IDLE) && start),
    .valid (rd_pending && (state == PASS1)),
    .data  (fifo.fifo_data),
    .sum   (sum)
  );

  // Mean of a power-of-2 frame is a shift; the quotient always fits a pixel.
  assign calc_thresh = DATA_WIDTH'(sum >> $clog2(FRAME_PIXELS));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      threshold     <= '0;
      pix_out       <= 1'b0;
      pix_out_valid <= 1'b0;
    end else begin
      if (state == CALC) threshold <= calc_thresh;
      pix_out_valid <= rd_pending && (state == PASS2);
      pix_out       <= rd_pending && (state == PASS2) && (fifo.fifo_data >= threshold);
    end
  end

endmodule

// File: tb/tb_dual_pass_threshold_reader.sv
// Self-checking bench: FIFO model replays each frame twice; expectations come from
// a frame-level threshold model (mean, or midrange under MIDRANGE_THRESH_EN).
module tb_dual_pass_threshold_reader;
  localparam int DW = 8;
  localparam int FP = 4;
  typedef logic [DW-1:0] frame_t [FP];

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] threshold;
  logic          pix_out, pix_out_valid, busy, done;

  dual_pass_threshold_reader_if #(.DATA_WIDTH(DW)) fif ();

  dual_pass_threshold_reader #(.DATA_WIDTH(DW), .FRAME_PIXELS(FP)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .fifo          (fif),
    .threshold     (threshold),
    .pix_out       (pix_out),
    .pix_out_valid (pix_out_valid),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // FIFO model
  logic [DW-1:0] mem [0:1023];
  int  wr_ptr = 0, rd_ptr = 0, reads = 0, bad_reads = 0, done_cnt = 0;
  bit  flush_req = 0, stall_man = 0, stall_rand = 0, rand_en = 0;
  logic outs [$];

  always_comb fif.fifo_empty = (rd_ptr == wr_ptr) || stall_man || stall_rand;

  always @(posedge clk) begin
    if (flush_req) rd_ptr <= wr_ptr;
    else if (fif.fifo_read_en) begin
      if (fif.fifo_empty) bad_reads <= bad_reads + 1;
      else begin
        fif.fifo_data <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1;
        reads  <= reads + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (pix_out_valid) outs.push_back(pix_out);
    if (done) done_cnt <= done_cnt + 1;
    stall_rand <= rand_en && ($urandom_range(2) == 0);
  end

  function automatic logic [DW-1:0] ref_thresh(input frame_t f);
    int s = 0, mn = 1 << DW, mx = -1;
    for (int i = 0; i < FP; i++) begin
      s += f[i];
      if (f[i] < mn) mn = f[i];
      if (f[i] > mx) mx = f[i];
    end
`ifdef MIDRANGE_THRESH_EN
    return DW'((mn + mx) / 2);
`else
    return DW'(s / FP);
`endif
  endfunction

  task automatic push_frame(input frame_t f, input int times);
    for (int t = 0; t < times; t++)
      for (int i = 0; i < FP; i++) begin
        mem[wr_ptr % 1024] = f[i];
        wr_ptr++;
      end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Returns one cycle after the done pulse (the IDLE cycle), or ok=0 on timeout.
  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_reads(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (reads >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if ({threshold, pix_out, pix_out_valid, busy, done, fif.fifo_read_en} !== '0) begin
      fails++; $display("FAIL reset_outputs got thr=%0d pix=%b vld=%b busy=%b done=%b rd=%b want all 0",
        threshold, pix_out, pix_out_valid, busy, done, fif.fifo_read_en);
    end
    @(negedge clk) reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0 || fif.fifo_read_en !== 1'b0) begin
      fails++; $display("FAIL idle_after_reset got busy=%b rd=%b want 0 0", busy, fif.fifo_read_en);
    end
  endtask

  // Directed boundary frames then random frames, half with random FIFO stalls.
  task automatic test_patterns();
    frame_t dir [6] = '{'{10, 20, 30, 40}, '{255, 255, 255, 255}, '{10, 10, 10, 250},
                        '{25, 25, 25, 25}, '{0, 0, 0, 1}, '{0, 0, 0, 0}};
    frame_t f;
    logic [DW-1:0] exp_t;
    int o0, r0, b0, d0;
    bit ok;
    for (int k = 0; k < 14; k++) begin
      if (k < 6) f = dir[k];
      else for (int i = 0; i < FP; i++) f[i] = DW'($urandom);
      rand_en = (k >= 10);
      exp_t = ref_thresh(f);
      o0 = outs.size(); r0 = reads; b0 = bad_reads; d0 = done_cnt;
      push_frame(f, 2);
      pulse_start();
      wait_done(ok);
      rand_en = 1'b0;
      tests++; if (!ok) begin fails++; $display("FAIL pat%0d_timeout got no done want done", k); end
      tests++; if (threshold !== exp_t) begin
        fails++; $display("FAIL pat%0d_threshold got %0d want %0d", k, threshold, exp_t);
      end
      tests++; if (outs.size() - o0 != FP) begin
        fails++; $display("FAIL pat%0d_out_count got %0d want %0d", k, outs.size() - o0, FP);
      end
      for (int i = 0; i < FP && o0 + i < outs.size(); i++) begin
        tests++; if (outs[o0 + i] !== (f[i] >= exp_t)) begin
          fails++; $display("FAIL pat%0d_pix%0d got %b want %b", k, i, outs[o0 + i], f[i] >= exp_t);
        end
      end
      tests++; if (reads - r0 != 2 * FP || bad_reads != b0) begin
        fails++; $display("FAIL pat%0d_reads got %0d bad=%0d want %0d bad=0", k, reads - r0, bad_reads - b0, 2 * FP);
      end
      tests++; if (done_cnt - d0 != 1 || busy !== 1'b0) begin
        fails++; $display("FAIL pat%0d_done got pulses=%0d busy=%b want 1 0", k, done_cnt - d0, busy);
      end
    end
  endtask

  task automatic test_stall();
    frame_t f = '{10, 20, 30, 40};
    logic [DW-1:0] exp_t = ref_thresh(f);
    int o0 = outs.size(), r0 = reads, b0 = bad_reads;
    bit ok;
    push_frame(f, 2);
    pulse_start();
    wait_reads(r0 + 2, ok);
    tests++; if (!ok) begin fails++; $display("FAIL stall_wait got timeout want 2 reads"); end
    stall_man = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      tests++; if (fif.fifo_read_en !== 1'b0) begin
        fails++; $display("FAIL stall_rd_en_c%0d got %b want 0", c, fif.fifo_read_en);
      end
    end
    @(negedge clk) stall_man = 1'b0;
    wait_done(ok);
    tests++; if (!ok || threshold !== exp_t) begin
      fails++; $display("FAIL stall_threshold got %0d ok=%b want %0d", threshold, ok, exp_t);
    end
    tests++; if (reads - r0 != 2 * FP || bad_reads != b0 || outs.size() - o0 != FP) begin
      fails++; $display("FAIL stall_counts got reads=%0d bad=%0d outs=%0d want %0d 0 %0d",
        reads - r0, bad_reads - b0, outs.size() - o0, 2 * FP, FP);
    end
    for (int i = 0; i < FP && o0 + i < outs.size(); i++) begin
      tests++; if (outs[o0 + i] !== (f[i] >= exp_t)) begin
        fails++; $display("FAIL stall_pix%0d got %b want %b", i, outs[o0 + i], f[i] >= exp_t);
      end
    end
  endtask

  task automatic test_control();
    frame_t f1 = '{50, 60, 70, 80};
    frame_t f2 = '{1, 2, 3, 4};
    frame_t f3 = '{100, 0, 100, 0};
    logic [DW-1:0] exp_t;
    int o0, r0, d0;
    bit ok;
    // start during pass 2 must not disturb the frame
    exp_t = ref_thresh(f1);
    o0 = outs.size(); r0 = reads; d0 = done_cnt;
    push_frame(f1, 2);
    pulse_start();
    wait_reads(r0 + FP + 1, ok);
    pulse_start();
    wait_done(ok);
    tests++; if (!ok || threshold !== exp_t || outs.size() - o0 != FP || reads - r0 != 2 * FP) begin
      fails++; $display("FAIL ctl_start_ignored got thr=%0d outs=%0d reads=%0d want %0d %0d %0d",
        threshold, outs.size() - o0, reads - r0, exp_t, FP, 2 * FP);
    end
    for (int i = 0; i < FP && o0 + i < outs.size(); i++) begin
      tests++; if (outs[o0 + i] !== (f1[i] >= exp_t)) begin
        fails++; $display("FAIL ctl_pix%0d got %b want %b", i, outs[o0 + i], f1[i] >= exp_t);
      end
    end
    repeat (3) @(posedge clk); #1;
    tests++; if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      fails++; $display("FAIL ctl_single_done got %0d busy=%b want 1 0", done_cnt - d0, busy);
    end
    // reset mid pass 2
    r0 = reads;
    push_frame(f2, 2);
    pulse_start();
    wait_reads(r0 + FP + 2, ok);
    reset = 1'b1;
    #1;
    tests++; if ({threshold, pix_out, pix_out_valid, busy, done, fif.fifo_read_en} !== '0) begin
      fails++; $display("FAIL ctl_reset_mid got thr=%0d pix=%b vld=%b busy=%b done=%b rd=%b want all 0",
        threshold, pix_out, pix_out_valid, busy, done, fif.fifo_read_en);
    end
    flush_req = 1'b1;
    @(posedge clk); #1 flush_req = 1'b0;
    @(negedge clk) reset = 1'b0;
    // fresh frame after reset
    exp_t = ref_thresh(f3);
    o0 = outs.size(); r0 = reads;
    push_frame(f3, 2);
    pulse_start();
    wait_done(ok);
    tests++; if (!ok || threshold !== exp_t || outs.size() - o0 != FP || reads - r0 != 2 * FP) begin
      fails++; $display("FAIL ctl_after_reset got thr=%0d outs=%0d reads=%0d want %0d %0d %0d",
        threshold, outs.size() - o0, reads - r0, exp_t, FP, 2 * FP);
    end
    for (int i = 0; i < FP && o0 + i < outs.size(); i++) begin
      tests++; if (outs[o0 + i] !== (f3[i] >= exp_t)) begin
        fails++; $display("FAIL ctl_rst_pix%0d got %b want %b", i, outs[o0 + i], f3[i] >= exp_t);
      end
    end
  endtask

  task automatic test_back_to_back();
    frame_t fa = '{10, 20, 30, 40};
    frame_t fb = '{200, 0, 0, 0};
    logic [DW-1:0] ta = ref_thresh(fa), tb_t = ref_thresh(fb);
    int o0 = outs.size(), d0 = done_cnt;
    bit ok;
    push_frame(fa, 2);
    push_frame(fb, 2);
    pulse_start();
    wait_done(ok);
    tests++; if (!ok || threshold !== ta) begin
      fails++; $display("FAIL b2b_thr_a got %0d ok=%b want %0d", threshold, ok, ta);
    end
    // currently in the IDLE cycle right after DONE
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept got busy=%b want 1", busy); end
    wait_done(ok);
    tests++; if (!ok || threshold !== tb_t) begin
      fails++; $display("FAIL b2b_thr_b got %0d ok=%b want %0d", threshold, ok, tb_t);
    end
    tests++; if (outs.size() - o0 != 2 * FP || done_cnt - d0 != 2) begin
      fails++; $display("FAIL b2b_counts got outs=%0d dones=%0d want %0d 2", outs.size() - o0, done_cnt - d0, 2 * FP);
    end
    for (int i = 0; i < 2 * FP && o0 + i < outs.size(); i++) begin
      logic want;
      want = (i < FP) ? (fa[i] >= ta) : (fb[i - FP] >= tb_t);
      tests++; if (outs[o0 + i] !== want) begin
        fails++; $display("FAIL b2b_pix%0d got %b want %b", i, outs[o0 + i], want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_stall();
    test_control();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
